// File: rtl/pc_gen_pkg.sv
// Shared types and default parameter values for the fetch-stage program-counter generator.
package pc_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } pc_state_e;

    localparam logic [31:0] DEF_RESET_VEC  = 32'h0000_0000;
    localparam int          DEF_STEP       = 4;
    localparam int          DEF_ALIGN_BITS = 2;

endpackage

// File: rtl/pc_gen_next_sel.sv
// Next-pc priority mux (trap > branch > handshake > hold) with branch-target alignment check.
module pc_next_sel
    import pc_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int STEP       = DEF_STEP,
    parameter int ALIGN_BITS = DEF_ALIGN_BITS
) (
    input  pc_state_e         state,
    input  logic [XLEN-1:0]   pc,
    input  logic              hs,
    input  logic              trap_valid,
    input  logic [XLEN-1:0]   trap_pc,
    input  logic              br_valid,
    input  logic [XLEN-1:0]   br_pc,
    output logic [XLEN-1:0]   next_pc,
    output pc_state_e         next_state,
    output logic              fault_set,
    output logic              fault_clr
);

    localparam logic [XLEN-1:0] STEP_X     = XLEN'(STEP);
    localparam logic [XLEN-1:0] ALIGN_MASK = {XLEN{1'b1}} << ALIGN_BITS;

    logic br_misaligned;
    assign br_misaligned = |(br_pc & ~ALIGN_MASK);

    always_comb begin
        next_pc    = pc;
        next_state = state;
        fault_set  = 1'b0;
        fault_clr  = 1'b0;
        // BOOT is a single settling cycle; any redirect below still overrides it
        if (state == BOOT) next_state = RUN;
        if (trap_valid) begin
            next_pc    = trap_pc & ALIGN_MASK;
            next_state = RUN;
            fault_clr  = 1'b1;
        end else if (br_valid && state != FAULT) begin
            if (br_misaligned) begin
                next_state = FAULT;
                fault_set  = 1'b1;
            end else begin
                next_pc    = br_pc;
                next_state = RUN;
            end
        end else if (hs) begin
            next_pc = pc + STEP_X;
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage program counter: holds the fetch address, handshakes with imem, counts accepted fetches.
module pc_gen
    import pc_pkg::*;
#(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_VEC  = XLEN'(DEF_RESET_VEC),
    parameter int              STEP       = DEF_STEP,
    parameter int              ALIGN_BITS = DEF_ALIGN_BITS,
    parameter int              CNT_W      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              trap_valid,
    input  logic [XLEN-1:0]   trap_pc,
    input  logic              br_valid,
    input  logic [XLEN-1:0]   br_pc,
    output logic              fetch_valid,
    input  logic              fetch_ready,
    output logic [XLEN-1:0]   pc_out,
    output logic              fault,
    output logic [XLEN-1:0]   fault_pc,
    output logic [CNT_W-1:0]  fetch_count
);

    pc_state_e         state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic              fault_q, fault_d;
    logic [XLEN-1:0]   fault_pc_q, fault_pc_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              hs, fault_set, fault_clr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= BOOT;
            pc_q       <= RESET_VEC;
            fault_q    <= 1'b0;
            fault_pc_q <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            fault_q    <= fault_d;
            fault_pc_q <= fault_pc_d;
            count_q    <= count_d;
        end
    end

    pc_next_sel #(
        .XLEN       (XLEN),
        .STEP       (STEP),
        .ALIGN_BITS (ALIGN_BITS)
    ) u_next_sel (
        .state      (state_q),
        .pc         (pc_q),
        .hs         (hs),
        .trap_valid (trap_valid),
        .trap_pc    (trap_pc),
        .br_valid   (br_valid),
        .br_pc      (br_pc),
        .next_pc    (pc_d),
        .next_state (state_d),
        .fault_set  (fault_set),
        .fault_clr  (fault_clr)
    );

    always_comb begin
        fetch_valid = (state_q == RUN) && !stall;
        hs          = fetch_valid && fetch_ready;
    end

    // An accepted fetch counts even when a redirect replaces the pc in the same cycle
    always_comb begin
        fault_d    = fault_q;
        fault_pc_d = fault_pc_q;
        count_d    = hs ? count_q + CNT_W'(1) : count_q;
        if (fault_set) begin
            fault_d    = 1'b1;
            fault_pc_d = br_pc;
        end else if (fault_clr) begin
            fault_d    = 1'b0;
        end
    end

    assign pc_out      = pc_q;
    assign fault       = fault_q;
    assign fault_pc    = fault_pc_q;
    assign fetch_count = count_q;

endmodule
